// File: rtl/hdmi_frame_pack.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_frame_pack
// Purpose  : 2:1 horizontal / 2:1 vertical decimation of an RGB565 stream and
//            packing of four kept pixels per 64-bit write-FIFO word.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_frame_pack #(
    parameter int PIX_W  = 16,
    parameter int PACK_N = 4,
    parameter int CNT_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vs_in,
    input  logic                    de_in,
    input  logic [PIX_W-1:0]        pix_in,
    input  logic                    fifo_full,
    output logic                    wr_en,
    output logic [PIX_W*PACK_N-1:0] wr_data,
    output logic                    frame_start,
    output logic                    line_done,
    output logic [CNT_W-1:0]        line_cnt,
    output logic                    overflow
);

    localparam int DATA_W = PIX_W * PACK_N;
    localparam int BUF_W  = PIX_W * (PACK_N - 1);
    localparam int SLOT_W = 2;
    localparam logic [SLOT_W-1:0] C_LAST_SLOT = SLOT_W'(PACK_N - 1);

    logic              vs_d_q,          vs_d_d;
    logic              de_d_q,          de_d_d;
    logic [CNT_W-1:0]  col_q,           col_d;
    logic [CNT_W-1:0]  line_cnt_q,      line_cnt_d;
    logic [SLOT_W-1:0] slot_q,          slot_d;
    logic [BUF_W-1:0]  buf_q,           buf_d;
    logic              pend_q,          pend_d;
    logic [DATA_W-1:0] pend_data_q,     pend_data_d;
    logic              wr_en_q,         wr_en_d;
    logic [DATA_W-1:0] wr_data_q,       wr_data_d;
    logic              frame_start_q,   frame_start_d;
    logic              line_done_q,     line_done_d;
    logic              overflow_q,      overflow_d;

    logic              vs_rise;
    logic              de_fall;
    logic              keep;
    logic              issue;
    logic [DATA_W-1:0] issue_data;

    // Edge detection, decimation, packing and write-issue decisions.
    // A completed word is held one cycle in the pending stage before fifo_full
    // is consulted; a line-end flush goes straight to the write stage.
    always_comb begin
        vs_rise       = vs_in & ~vs_d_q;
        de_fall       = ~de_in & de_d_q;
        keep          = de_in & ~col_q[0] & ~line_cnt_q[0];

        vs_d_d        = vs_in;
        de_d_d        = de_in;
        col_d         = col_q;
        line_cnt_d    = line_cnt_q;
        slot_d        = slot_q;
        buf_d         = buf_q;
        pend_d        = 1'b0;
        pend_data_d   = pend_data_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        frame_start_d = 1'b0;
        line_done_d   = 1'b0;
        overflow_d    = overflow_q;
        issue         = 1'b0;
        issue_data    = '0;

        if (vs_rise) begin
            // Frame start wins over everything: drop partial pack and any write.
            frame_start_d = 1'b1;
            line_cnt_d    = '0;
            col_d         = '0;
            slot_d        = '0;
            buf_d         = '0;
        end else begin
            if (pend_q) begin
                issue      = 1'b1;
                issue_data = pend_data_q;
            end

            if (de_in) begin
                col_d = col_q + 1'b1;
            end

            if (keep) begin
                if (slot_q == C_LAST_SLOT) begin
                    pend_d      = 1'b1;
                    pend_data_d = {pix_in, buf_q};
                    buf_d       = '0;
                    slot_d      = '0;
                end else begin
                    for (int k = 0; k < PACK_N - 1; k++) begin
                        if (slot_q == SLOT_W'(k)) begin
                            buf_d[k*PIX_W +: PIX_W] = pix_in;
                        end
                    end
                    slot_d = slot_q + 1'b1;
                end
            end

            if (de_fall) begin
                col_d       = '0;
                line_done_d = 1'b1;
                slot_d      = '0;
                buf_d       = '0;
                if (line_cnt_q != {CNT_W{1'b1}}) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
                // Unfilled upper slots are already zero in the buffer.
                if (slot_q != '0) begin
                    issue      = 1'b1;
                    issue_data = {{PIX_W{1'b0}}, buf_q};
                end
            end

            if (issue) begin
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = issue_data;
                end
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d_q        <= 1'b0;
            de_d_q        <= 1'b0;
            col_q         <= '0;
            line_cnt_q    <= '0;
            slot_q        <= '0;
            buf_q         <= '0;
            pend_q        <= 1'b0;
            pend_data_q   <= '0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            frame_start_q <= 1'b0;
            line_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            vs_d_q        <= vs_d_d;
            de_d_q        <= de_d_d;
            col_q         <= col_d;
            line_cnt_q    <= line_cnt_d;
            slot_q        <= slot_d;
            buf_q         <= buf_d;
            pend_q        <= pend_d;
            pend_data_q   <= pend_data_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            frame_start_q <= frame_start_d;
            line_done_q   <= line_done_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign frame_start = frame_start_q;
    assign line_done   = line_done_q;
    assign line_cnt    = line_cnt_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_frame_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_frame_pack
// Purpose  : Directed self-checking bench for hdmi_frame_pack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_frame_pack;

    localparam logic [63:0] C_FULL_WORD  = 64'h0006_0004_0002_0000;
    localparam logic [63:0] C_FLUSH_WORD = 64'h0000_0004_0002_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs_in;
    logic        de_in;
    logic [15:0] pix_in;
    logic        fifo_full;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        frame_start;
    logic        line_done;
    logic [11:0] line_cnt;
    logic        overflow;

    hdmi_frame_pack dut (
        .clk         (clk),
        .rst         (rst),
        .vs_in       (vs_in),
        .de_in       (de_in),
        .pix_in      (pix_in),
        .fifo_full   (fifo_full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .line_done   (line_done),
        .line_cnt    (line_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Running event totals, sampled on the falling edge.
    int          n_wr    = 0;
    int          n_fs    = 0;
    int          n_ld    = 0;
    int          n_wr_ld = 0;
    logic [63:0] wd [0:63];
    int          wc [0:63];

    always @(negedge clk) begin
        if (wr_en) begin
            if (n_wr < 64) begin
                wd[n_wr] = wr_data;
                wc[n_wr] = cyc;
            end
            if (line_done) n_wr_ld++;
            n_wr++;
        end
        if (frame_start) n_fs++;
        if (line_done)   n_ld++;
    end

    int n_chk = 0;
    int n_err = 0;
    int px6_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        de_in  = 1'b0;
        pix_in = '0;
        repeat (n) tick();
    endtask

    task automatic vs_pulse();
        vs_in = 1'b1;
        tick();
        tick();
        vs_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_line(input int n);
        for (int c = 0; c < n; c++) begin
            de_in  = 1'b1;
            pix_in = 16'(c);
            if (c == 6) px6_cyc = cyc;
            tick();
        end
        idle(4);
    endtask

    int b_wr, b_fs, b_ld, b_wl, p0;

    initial begin
        rst = 1'b1; vs_in = 1'b0; de_in = 1'b0; pix_in = '0; fifo_full = 1'b0;

        // ---------------- reset with toggling inputs ----------------
        for (int i = 0; i < 3; i++) begin
            vs_in  = i[0];
            de_in  = ~i[0];
            pix_in = 16'($urandom);
            tick();
        end
        check("rst_wr_en",       64'(wr_en),       64'd0);
        check("rst_frame_start", 64'(frame_start), 64'd0);
        check("rst_line_done",   64'(line_done),   64'd0);
        check("rst_overflow",    64'(overflow),    64'd0);
        check("rst_line_cnt",    64'(line_cnt),    64'd0);
        check("rst_wr_data",     wr_data,          64'd0);
        rst = 1'b0; vs_in = 1'b0;
        idle(3);

        // ---------------- 4 lines x 8 pixels ----------------
        b_wr = n_wr; b_fs = n_fs; b_ld = n_ld;
        vs_pulse();
        send_line(8);
        p0 = px6_cyc;
        send_line(8);
        send_line(8);
        send_line(8);
        check("frm_fs_count",  64'(n_fs - b_fs), 64'd1);
        check("frm_wr_count",  64'(n_wr - b_wr), 64'd2);
        check("frm_word0",     wd[b_wr],         C_FULL_WORD);
        check("frm_word1",     wd[b_wr + 1],     C_FULL_WORD);
        check("frm_latency",   64'(wc[b_wr]),    64'(p0 + 2));
        check("frm_ld_count",  64'(n_ld - b_ld), 64'd4);
        check("frm_line_cnt",  64'(line_cnt),    64'd4);
        check("frm_overflow",  64'(overflow),    64'd0);

        // ---------------- 6-pixel line: flush ----------------
        vs_pulse();
        check("fl_line_cnt_clr", 64'(line_cnt), 64'd0);
        b_wr = n_wr; b_wl = n_wr_ld;
        send_line(6);
        check("fl_wr_count",  64'(n_wr - b_wr),    64'd1);
        check("fl_word",      wd[b_wr],            C_FLUSH_WORD);
        check("fl_with_ld",   64'(n_wr_ld - b_wl), 64'd1);

        // ---------------- fifo_full drop ----------------
        vs_pulse();
        b_wr = n_wr;
        fifo_full = 1'b1;
        send_line(8);
        fifo_full = 1'b0;
        check("ov_no_write",  64'(n_wr - b_wr), 64'd0);
        check("ov_set",       64'(overflow),    64'd1);
        send_line(8);
        send_line(8);
        check("ov_next_cnt",  64'(n_wr - b_wr), 64'd1);
        check("ov_next_word", wd[b_wr],         C_FULL_WORD);
        check("ov_sticky",    64'(overflow),    64'd1);

        // ---------------- vs rise mid-line ----------------
        vs_pulse();
        send_line(8);
        send_line(8);
        check("vm_line_cnt2", 64'(line_cnt), 64'd2);
        b_wr = n_wr; b_fs = n_fs; b_ld = n_ld;
        for (int c = 0; c < 3; c++) begin
            de_in = 1'b1; pix_in = 16'(c);
            tick();
        end
        de_in = 1'b0; pix_in = '0; vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        idle(4);
        check("vm_no_write",  64'(n_wr - b_wr), 64'd0);
        check("vm_fs",        64'(n_fs - b_fs), 64'd1);
        check("vm_no_ld",     64'(n_ld - b_ld), 64'd0);
        check("vm_line_cnt0", 64'(line_cnt),    64'd0);
        send_line(8);
        check("vm_next_cnt",  64'(n_wr - b_wr), 64'd1);
        check("vm_next_word", wd[b_wr],         C_FULL_WORD);

        // ---------------- reset mid-line ----------------
        vs_pulse();
        b_wr = n_wr; b_ld = n_ld;
        for (int c = 0; c < 5; c++) begin
            de_in = 1'b1; pix_in = 16'(c);
            tick();
        end
        pix_in = 16'd5; rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(4);
        check("rm_no_flush",  64'(n_wr - b_wr), 64'd0);
        check("rm_no_ld",     64'(n_ld - b_ld), 64'd0);
        check("rm_line_cnt",  64'(line_cnt),    64'd0);
        check("rm_overflow",  64'(overflow),    64'd0);
        send_line(8);
        check("rm_next_cnt",  64'(n_wr - b_wr), 64'd1);
        check("rm_next_word", wd[b_wr],         C_FULL_WORD);
        check("rm_line_cnt1", 64'(line_cnt),    64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
